// File: rtl/score_segments_pkg.sv
// Shared types and constants for the score display: BCD digit types,
// the seven-segment pattern table and the converter state encoding.
package snakePkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] digit_t;
  typedef digit_t [4:0] bcd5_t;

  localparam byte_t SEG_BLANK = 8'hFF;

  // Active-low a..g patterns for 0..9, entry 0 in the low byte; dp stays off
  localparam logic [9:0][7:0] SEG_PAT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } dd_state_t;

  function automatic byte_t seg_of(digit_t d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_PAT[d];
  endfunction

endpackage

// File: rtl/score_segments_if.sv
// Score request / display bus between the game logic and the segment driver.
interface score_segments_if #(parameter int SCORE_W = 16);
  import snakePkg::*;

  logic [SCORE_W-1:0] score;
  logic               score_valid;
  byte_t              AN;
  byte_t              CA;
  logic               busy;

  modport master (output score, score_valid, AN, input CA, busy);
  modport slave  (input score, score_valid, AN, output CA, busy);

endinterface

// File: rtl/score_segments_double_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per cycle,
// with a one-entry latest-wins request buffer used while a conversion runs.
//
// state | meaning
// IDLE  | waiting for score_valid; busy low
// CONV  | shifting; result handed out on the SCORE_W-th shift
module double_dabble
  import snakePkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic               done,
  output bcd5_t              result
);

  localparam int W = 20 + SCORE_W;
  localparam logic [4:0] LAST_CNT = 5'(SCORE_W - 1);

  dd_state_t          state, state_nxt;
  logic [4:0]         cnt, cnt_nxt;
  logic [SCORE_W-1:0] bin, bin_nxt;
  logic [19:0]        bcd, bcd_nxt;
  logic               pend_v, pend_v_nxt;
  logic [SCORE_W-1:0] pend_val, pend_val_nxt;

  logic [19:0]        bcd_adj;
  logic [W-1:0]       shifted;
  logic               last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bin      <= '0;
      bcd      <= '0;
      pend_v   <= 1'b0;
      pend_val <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bin      <= bin_nxt;
      bcd      <= bcd_nxt;
      pend_v   <= pend_v_nxt;
      pend_val <= pend_val_nxt;
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < 5; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
  end

  assign last   = (state == CONV) && (cnt == LAST_CNT);
  assign busy   = (state == CONV);
  assign result = bcd5_t'(shifted[W-1 -: 20]);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bin_nxt      = bin;
    bcd_nxt      = bcd;
    pend_v_nxt   = pend_v;
    pend_val_nxt = pend_val;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (score_valid) begin
          state_nxt = CONV;
          bin_nxt   = score;
          bcd_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      CONV: begin
        bin_nxt = shifted[SCORE_W-1:0];
        bcd_nxt = shifted[W-1 -: 20];
        cnt_nxt = cnt + 5'd1;
        if (last) begin
          done    = 1'b1;
          cnt_nxt = '0;
          // A request arriving on the final edge is newer than the buffered one
          if (score_valid || pend_v) begin
            bin_nxt    = score_valid ? score : pend_val;
            bcd_nxt    = '0;
            pend_v_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (score_valid) begin
          pend_v_nxt   = 1'b1;
          pend_val_nxt = score;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/score_segments.sv
// Score-to-seven-segment driver: converts a binary score to BCD and drives
// the cathodes for whichever digit the refresh stage selects on AN.
module score_segments
  import snakePkg::*;
#(
  parameter int nSeg    = 8,
  parameter int SCORE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  score_segments_if.slave   bus
);

  logic       busy;
  logic       done;
  bcd5_t      result;
  bcd5_t      disp;
  byte_t      ca_q, ca_nxt;
  logic [3:0] zeros;
  logic [2:0] idx, msd;
  digit_t     dig;

  double_dabble #(.SCORE_W(SCORE_W)) u_dd (
    .clk         (clk),
    .rst         (rst),
    .score       (bus.score),
    .score_valid (bus.score_valid),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  assign bus.busy = busy;
  assign bus.CA   = ca_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) disp <= '0;
    else if (done) disp <= result;
  end

  always_comb begin
    zeros = '0;
    idx   = '0;
    for (int i = 0; i < nSeg; i++) begin
      if (!bus.AN[i]) begin
        zeros = zeros + 4'd1;
        idx   = 3'(i);
      end
    end
    msd = '0;
    for (int i = 0; i < 5; i++) begin
      if (disp[i] != 4'd0) msd = 3'(i);
    end
    dig = '0;
    for (int i = 0; i < 5; i++) begin
      if (idx == 3'(i)) dig = disp[i];
    end
    // msd never exceeds 4, so this also blanks indices 5..7
    ca_nxt = SEG_BLANK;
    if (zeros == 4'd1 && idx <= msd) ca_nxt = seg_of(dig);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ca_q <= SEG_BLANK;
    else ca_q <= ca_nxt;
  end

endmodule

// File: tb/tb_score_segments.sv
// Directed bench for score_segments: table of score/AN/CA vectors plus
// hand-written reset, busy-length and pending-request sequences.
module tb_score_segments;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  score_segments_if #(.SCORE_W(16)) bus ();

  score_segments #(.nSeg(8), .SCORE_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         score;   // -1: keep current display
    logic [7:0] an;
    logic [7:0] ca;
  } vec_t;

  vec_t vecs[23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.score_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic load(input int val, input string name);
    int n;
    bus.score = 16'(val);
    bus.score_valid = 1'b1;
    step();
    bus.score_valid = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    check(name, n, 16);
  endtask

  initial begin
    int n;
    logic seen42;

    bus.score = '0;
    bus.score_valid = 1'b0;
    bus.AN = 8'hFF;

    vecs = '{
      '{1234,  8'hFE, 8'h99}, '{-1, 8'hFD, 8'hB0}, '{-1, 8'hFB, 8'hA4},
      '{-1,    8'hF7, 8'hF9}, '{-1, 8'hEF, 8'hFF},
      '{65535, 8'hFE, 8'h92}, '{-1, 8'hFD, 8'hB0}, '{-1, 8'hFB, 8'h92},
      '{-1,    8'hF7, 8'h92}, '{-1, 8'hEF, 8'h82}, '{-1, 8'hDF, 8'hFF},
      '{-1,    8'hBF, 8'hFF}, '{-1, 8'h7F, 8'hFF},
      '{-1,    8'hFC, 8'hFF}, '{-1, 8'hFF, 8'hFF}, '{-1, 8'h00, 8'hFF},
      '{1000,  8'hFE, 8'hC0}, '{-1, 8'hFD, 8'hC0}, '{-1, 8'hFB, 8'hC0},
      '{-1,    8'hF7, 8'hF9}, '{-1, 8'hEF, 8'hFF},
      '{0,     8'hFE, 8'hC0}, '{-1, 8'hFD, 8'hFF}
    };

    // Reset state and first edges after release
    step();
    check("rst_ca", bus.CA, 8'hFF);
    check("rst_busy", bus.busy, 0);
    rst = 1'b1;
    bus.AN = 8'hFE;
    step();
    check("rel_idx0", bus.CA, 8'hC0);
    bus.AN = 8'hFD;
    step();
    check("rel_idx1", bus.CA, 8'hFF);

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].score >= 0) load(vecs[i].score, $sformatf("busy_len_%0d", vecs[i].score));
      bus.AN = vecs[i].an;
      step();
      check($sformatf("vec%0d_an%02h", i, vecs[i].an), bus.CA, vecs[i].ca);
    end

    // Back-to-back requests: 42 is superseded by 99 before it is ever shown
    do_reset();
    bus.AN = 8'hFE;
    bus.score = 16'd7;
    bus.score_valid = 1'b1;
    step();
    bus.score_valid = 1'b0;
    n = 0;
    seen42 = 1'b0;
    while (bus.busy && n < 200) begin
      if (n == 3) begin
        bus.score = 16'd42;
        bus.score_valid = 1'b1;
      end else if (n == 8) begin
        bus.score = 16'd99;
        bus.score_valid = 1'b1;
      end else begin
        bus.score_valid = 1'b0;
      end
      if (bus.CA == 8'hA4) seen42 = 1'b1;
      step();
      n++;
    end
    bus.score_valid = 1'b0;
    check("pend_busy_len", n, 32);
    check("pend_no_42", seen42, 0);
    step();
    check("pend_idx0", bus.CA, 8'h90);
    bus.AN = 8'hFD;
    step();
    check("pend_idx1", bus.CA, 8'h90);
    bus.AN = 8'hFB;
    step();
    check("pend_idx2", bus.CA, 8'hFF);

    // Show 7 first, then confirm the display holds during a later conversion
    load(7, "busy_len_7");
    bus.AN = 8'hFE;
    bus.score = 16'd42;
    bus.score_valid = 1'b1;
    step();
    bus.score_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("hold_mid_conv", bus.CA, 8'hF8);
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    step();
    check("after_conv_42", bus.CA, 8'hA4);

    // Reset in the middle of converting 500
    bus.AN = 8'hFE;
    bus.score = 16'd500;
    bus.score_valid = 1'b1;
    step();
    bus.score_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("mid_busy_before", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ca", bus.CA, 8'hFF);
    step();
    rst = 1'b1;
    step();
    check("mid_rel_idx0", bus.CA, 8'hC0);
    bus.AN = 8'hFD;
    step();
    check("mid_rel_idx1", bus.CA, 8'hFF);
    for (int k = 0; k < 20; k++) step();
    check("mid_no_done_busy", bus.busy, 0);
    check("mid_no_done_idx1", bus.CA, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
